ct_f_spsram_512x44_req_ctrl: RTL

- Initiator-side controller for the 512x44 single-port SRAM macro port (A/CEN/GWEN/WEN/D/Q, all strobes active-low).
- Converts a valid/ready request channel into macro accesses.
- Captures read data one cycle after issue into a 2-entry response buffer with valid/ready back-pressure.
- After reset, zero-initialises all 512 entries before accepting requests.

---
 rtl/ct_f_spsram_ctrl_pkg.sv | 14 +
 rtl/ct_f_spsram_rsp_fifo.sv | 55 +++++
 rtl/ct_f_spsram_512x44_req_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared constants and FSM encoding for the 512x44 single-port SRAM request controller.
package ct_f_spsram_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_WIDTH = 9;
    localparam int unsigned SRAM_DATA_WIDTH = 44;
    localparam int unsigned SRAM_WRAP_SIZE  = 22;
    localparam int unsigned SRAM_DEPTH      = 512;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/ct_f_spsram_rsp_fifo.sv
// Two-entry read-response FIFO.
// Ports: CLK/RST, push + push_data (tail write), pop (head release, ignored when empty),
//        occ (entries held), vld (not empty), rdata (head entry).
module ct_f_spsram_rsp_fifo
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic                  vld,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            occ_q;
    logic                  pop_ok;

    assign pop_ok = pop & vld;
    assign occ    = occ_q;
    assign vld    = (occ_q != 2'd0);
    assign rdata  = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; push+pop together leaves occupancy unchanged.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop_ok})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/ct_f_spsram_512x44_req_ctrl.sv
// Initiator-side controller for a 512x44 single-port SRAM macro (active-low strobes).
// Zero-fills the array after reset, then turns valid/ready requests into macro accesses
// and returns read data through a 2-entry response buffer.
// Ports: CLK/RST; req_* request channel (req_rdy out); rsp_* response channel (rsp_rdy in);
//        init_done (sticky); sram_A/CEN/GWEN/WEN/D to the macro, sram_Q from the macro.
module ct_f_spsram_512x44_req_ctrl
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = SRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH    = SRAM_DATA_WIDTH,
    parameter int unsigned WRAP_SIZE     = SRAM_WRAP_SIZE,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_A,
    output logic                  sram_CEN,
    output logic                  sram_GWEN,
    output logic [DATA_WIDTH-1:0] sram_WEN,
    output logic [DATA_WIDTH-1:0] sram_D,
    input  logic [DATA_WIDTH-1:0] sram_Q
);

    localparam int unsigned HI_WIDTH = DATA_WIDTH - WRAP_SIZE;

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] a_q;
    logic                  rd_pend_q;
    logic                  rd_issue;
    logic [1:0]            occ;
    logic                  pop;
    logic [2:0]            credit;
    logic                  can_accept;

    // Slots committed for the next cycle: buffered + in flight - leaving now.
    assign pop        = rsp_vld & rsp_rdy;
    assign credit     = 3'(occ) + 3'(rd_pend_q) - 3'(pop);
    assign can_accept = (credit < 3'd2);

    // State, sweep counter, address hold, read-pending flag and init flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            cnt_q     <= '0;
            a_q       <= '0;
            rd_pend_q <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= sram_A;
            rd_pend_q <= rd_issue;
            init_done <= (state_d == ST_RUN);
        end
    end

    // Next state and macro pin mux; pins idle while RST is held so reset values show at once.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_rdy   = 1'b0;
        rd_issue  = 1'b0;
        sram_CEN  = 1'b1;
        sram_GWEN = 1'b1;
        sram_WEN  = '1;
        sram_D    = '0;
        sram_A    = a_q;
        if (!RST) begin
            case (state_q)
                ST_INIT: begin
                    sram_CEN  = 1'b0;
                    sram_GWEN = 1'b0;
                    sram_WEN  = '0;
                    sram_A    = cnt_q;
                    cnt_d     = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == ADDR_WIDTH'(SRAM_DEPTH - 1)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    req_rdy = can_accept;
                    if (req_vld && can_accept) begin
                        if (req_wr) begin
                            // An all-zero mask is consumed without touching the macro.
                            if (req_wmask != 2'b00) begin
                                sram_CEN  = 1'b0;
                                sram_GWEN = 1'b0;
                                sram_A    = req_addr;
                                sram_D    = req_wdata;
                                sram_WEN  = {{HI_WIDTH{~req_wmask[1]}}, {WRAP_SIZE{~req_wmask[0]}}};
                            end
                        end else begin
                            sram_CEN = 1'b0;
                            sram_A   = req_addr;
                            rd_issue = 1'b1;
                        end
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // Macro Q is valid the cycle after a read access; capture it into the buffer tail then.
    ct_f_spsram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (rd_pend_q),
        .push_data (sram_Q),
        .pop       (pop),
        .occ       (occ),
        .vld       (rsp_vld),
        .rdata     (rsp_rdata)
    );

endmodule
